// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg -- shared encodings for the iterative divider controller.
//   state_e          : controller state enum (IDLE, SWEEP, FIX, DONE)
//   ST_*             : the same encodings as plain logic [1:0] constants
//   EN_OFF/MID/LAST  : 2-bit strobe encodings for en_shift / en_borrow
package div_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_FIX   = 2'd2,
        S_DONE  = 2'd3
    } state_e;

    localparam logic [1:0] ST_IDLE  = S_IDLE;
    localparam logic [1:0] ST_SWEEP = S_SWEEP;
    localparam logic [1:0] ST_FIX   = S_FIX;
    localparam logic [1:0] ST_DONE  = S_DONE;

    localparam logic [1:0] EN_OFF  = 2'd0;
    localparam logic [1:0] EN_MID  = 2'd1;
    localparam logic [1:0] EN_LAST = 2'd2;

endpackage

// File: rtl/div_iter_ctrl_if.sv
// div_iter_ctrl_if -- control bundle between the divider controller and its
// datapath.
//   start, error_flag        : datapath -> controller
//   enable_all, en_cout, en_q, en_shift, en_borrow, en_v_upper, fixing,
//   wr_V_ram, rd_V_ram, busy, done, digit_cnt : controller -> datapath
// modport slave is the controller side, modport master the datapath side.
interface div_iter_ctrl_if #(
    parameter int NUM_DIGITS = 16,
    parameter int RAM_width  = 7
);
    localparam int DIGIT_W = $clog2(NUM_DIGITS + 1);

    logic                 start;
    logic                 error_flag;
    logic                 enable_all;
    logic                 en_cout;
    logic [1:0]           en_q;
    logic [1:0]           en_shift;
    logic [1:0]           en_borrow;
    logic                 en_v_upper;
    logic                 fixing;
    logic [RAM_width-1:0] wr_V_ram;
    logic [RAM_width-1:0] rd_V_ram;
    logic                 busy;
    logic                 done;
    logic [DIGIT_W-1:0]   digit_cnt;

    modport master (
        output start, error_flag,
        input  enable_all, en_cout, en_q, en_shift, en_borrow, en_v_upper,
               fixing, wr_V_ram, rd_V_ram, busy, done, digit_cnt
    );

    modport slave (
        input  start, error_flag,
        output enable_all, en_cout, en_q, en_shift, en_borrow, en_v_upper,
               fixing, wr_V_ram, rd_V_ram, busy, done, digit_cnt
    );

endinterface

// File: rtl/div_addr_gen.sv
// div_addr_gen -- V RAM address generation.
//   clk, async_clear : clock and synchronous active-high clear
//   ptr_clr          : return the write pointer to 0 (end of a division)
//   ptr_inc          : advance the write pointer (one residue line written)
//   rd_en            : fix pass active, read back this digit's lines
//   line_cnt         : current line within the digit
//   wr_addr          : write pointer, wraps modulo 2^RAM_width
//   rd_addr          : (wr pointer - LINES + line_cnt) mod 2^RAM_width, else 0
module div_addr_gen #(
    parameter int LINES     = 4,
    parameter int RAM_width = 7,
    parameter int LINE_W    = 2
) (
    input  logic                 clk,
    input  logic                 async_clear,
    input  logic                 ptr_clr,
    input  logic                 ptr_inc,
    input  logic                 rd_en,
    input  logic [LINE_W-1:0]    line_cnt,
    output logic [RAM_width-1:0] wr_addr,
    output logic [RAM_width-1:0] rd_addr
);

    logic [RAM_width-1:0] ptr_q;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (async_clear || ptr_clr) begin
            ptr_q <= '0;
        end else if (ptr_inc) begin
            ptr_q <= ptr_q + RAM_width'(1);   // natural wrap at 2^RAM_width
        end
    end

    assign wr_addr = ptr_q;

    // After a sweep the pointer sits LINES past the first line of the digit;
    // modular subtraction walks back over exactly those lines, across a wrap.
    assign rd_addr = rd_en ? (ptr_q - RAM_width'(LINES) + RAM_width'(line_cnt))
                           : '0;

endmodule

// File: rtl/div_iter_ctrl.sv
// div_iter_ctrl -- iteration controller for a digit-recurrence divider.
// Each quotient digit is a SWEEP over LINES residue lines (LSD line first),
// optionally followed by a FIX pass re-reading the same lines when the
// datapath flags the digit. After NUM_DIGITS digits a one-cycle DONE follows.
//   clk         : clock, rising edge
//   async_clear : synchronous active-high clear (name kept for compatibility)
//   bus         : div_iter_ctrl_if.slave -- start/error_flag in, strobes,
//                 V RAM addresses, busy/done and digit_cnt out
// All outputs decode registered state only.
module div_iter_ctrl
    import div_ctrl_pkg::*;
#(
    parameter int UNROLLING  = 4,
    parameter int LINES      = 4,
    parameter int NUM_DIGITS = 16,
    parameter int RAM_width  = 7
) (
    input  logic            clk,
    input  logic            async_clear,
    div_iter_ctrl_if.slave  bus
);

    localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int DIGIT_W = $clog2(NUM_DIGITS + 1);

    if (LINES < 2 || UNROLLING < 1 || NUM_DIGITS < 1) begin : g_param_check
        $error("div_iter_ctrl: LINES must be >= 2, UNROLLING and NUM_DIGITS >= 1");
    end

    logic [1:0]           state_q;
    logic [LINE_W-1:0]    line_q;
    logic [DIGIT_W-1:0]   digit_q;
    logic                 last_line;
    logic                 last_digit;
    logic [RAM_width-1:0] wr_addr;
    logic [RAM_width-1:0] rd_addr;

    assign last_line  = (line_q  == LINE_W'(LINES - 1));
    assign last_digit = (digit_q == DIGIT_W'(NUM_DIGITS - 1));

    // The clear is only looked at on the clock edge, so it sits inside the
    // clocked branch rather than in the sensitivity list.
    always_ff @(posedge clk) begin
        if (async_clear) begin
            state_q <= ST_IDLE;
            line_q  <= '0;
            digit_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_q <= ST_SWEEP;
                        line_q  <= '0;
                        digit_q <= '0;
                    end
                end
                ST_SWEEP: begin
                    if (last_line) begin
                        line_q <= '0;
                        if (bus.error_flag) begin
                            state_q <= ST_FIX;       // digit stays, re-read its lines
                        end else begin
                            digit_q <= digit_q + DIGIT_W'(1);
                            state_q <= last_digit ? ST_DONE : ST_SWEEP;
                        end
                    end else begin
                        line_q <= line_q + LINE_W'(1);
                    end
                end
                ST_FIX: begin
                    if (last_line) begin
                        line_q  <= '0;
                        digit_q <= digit_q + DIGIT_W'(1);
                        state_q <= last_digit ? ST_DONE : ST_SWEEP;
                    end else begin
                        line_q <= line_q + LINE_W'(1);
                    end
                end
                default: begin                       // ST_DONE
                    state_q <= ST_IDLE;
                    digit_q <= '0;
                end
            endcase
        end
    end

    div_addr_gen #(
        .LINES     (LINES),
        .RAM_width (RAM_width),
        .LINE_W    (LINE_W)
    ) u_addr_gen (
        .clk         (clk),
        .async_clear (async_clear),
        .ptr_clr     (state_q == ST_DONE),   // next division starts at address 0
        .ptr_inc     (state_q == ST_SWEEP),
        .rd_en       (state_q == ST_FIX),
        .line_cnt    (line_q),
        .wr_addr     (wr_addr),
        .rd_addr     (rd_addr)
    );

    // NOTE: every output gets a default before the case so no path through
    // this block leaves a value unassigned and infers a latch.
    always_comb begin
        bus.enable_all = 1'b0;
        bus.en_cout    = 1'b0;
        bus.en_q       = EN_OFF;
        bus.en_shift   = EN_OFF;
        bus.en_borrow  = EN_OFF;
        bus.en_v_upper = 1'b0;
        bus.fixing     = 1'b0;
        bus.busy       = (state_q != ST_IDLE);
        bus.done       = (state_q == ST_DONE);
        bus.digit_cnt  = digit_q;
        bus.wr_V_ram   = wr_addr;
        bus.rd_V_ram   = rd_addr;
        case (state_q)
            ST_SWEEP: begin
                bus.enable_all = 1'b1;
                bus.en_q       = (line_q == '0) ? 2'd1 : EN_OFF;  // quotient enters on the LSD line
                bus.en_cout    = !last_line;
                bus.en_shift   = last_line ? EN_LAST : EN_MID;
                bus.en_v_upper = last_line;
            end
            ST_FIX: begin
                bus.enable_all = 1'b1;
                bus.fixing     = 1'b1;
                bus.en_borrow  = last_line ? EN_LAST : EN_MID;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_div_iter_ctrl.sv
// tb_div_iter_ctrl -- self-checking bench for div_iter_ctrl.
// Two instances: A (LINES=4, NUM_DIGITS=2, RAM_width=7) and B (LINES=4,
// NUM_DIGITS=3, RAM_width=3, exercises address wrap). For each division the
// expected cycle-by-cycle outputs are listed up front from the digit/line
// rules, then compared at every falling edge.
module tb_div_iter_ctrl;

    typedef struct packed {
        logic       busy;
        logic       done;
        logic       enable_all;
        logic       en_cout;
        logic       en_v_upper;
        logic       fixing;
        logic [1:0] en_q;
        logic [1:0] en_shift;
        logic [1:0] en_borrow;
        logic [3:0] digit;
        logic [6:0] wr;
        logic [6:0] rd;
    } obs_t;

    typedef struct {
        obs_t exp;
        obs_t mask;
        bit   err_pt;   // error_flag is sampled at the end of this cycle
        int   dig;
    } step_t;

    logic clk = 1'b0;
    logic async_clear;
    int   checks = 0;
    int   errors = 0;
    step_t plan[$];

    always #5 clk = ~clk;

    div_iter_ctrl_if #(.NUM_DIGITS(2), .RAM_width(7)) if_a ();
    div_iter_ctrl_if #(.NUM_DIGITS(3), .RAM_width(3)) if_b ();

    div_iter_ctrl #(.UNROLLING(4), .LINES(4), .NUM_DIGITS(2), .RAM_width(7)) dut_a (
        .clk         (clk),
        .async_clear (async_clear),
        .bus         (if_a)
    );

    div_iter_ctrl #(.UNROLLING(4), .LINES(4), .NUM_DIGITS(3), .RAM_width(3)) dut_b (
        .clk         (clk),
        .async_clear (async_clear),
        .bus         (if_b)
    );

    function automatic obs_t sample(input int which);
        obs_t o;
        o = '0;
        if (which == 0) begin
            o.busy = if_a.busy;         o.done = if_a.done;
            o.enable_all = if_a.enable_all; o.en_cout = if_a.en_cout;
            o.en_v_upper = if_a.en_v_upper; o.fixing = if_a.fixing;
            o.en_q = if_a.en_q;         o.en_shift = if_a.en_shift;
            o.en_borrow = if_a.en_borrow;
            o.digit = 4'(if_a.digit_cnt);
            o.wr = 7'(if_a.wr_V_ram);   o.rd = 7'(if_a.rd_V_ram);
        end else begin
            o.busy = if_b.busy;         o.done = if_b.done;
            o.enable_all = if_b.enable_all; o.en_cout = if_b.en_cout;
            o.en_v_upper = if_b.en_v_upper; o.fixing = if_b.fixing;
            o.en_q = if_b.en_q;         o.en_shift = if_b.en_shift;
            o.en_borrow = if_b.en_borrow;
            o.digit = 4'(if_b.digit_cnt);
            o.wr = 7'(if_b.wr_V_ram);   o.rd = 7'(if_b.rd_V_ram);
        end
        return o;
    endfunction

    task automatic drive(input int which, input logic s, input logic e);
        if (which == 0) begin
            if_a.start = s; if_a.error_flag = e;
        end else begin
            if_b.start = s; if_b.error_flag = e;
        end
    endtask

    task automatic check(input string tag, input obs_t got, input obs_t exp, input obs_t mask);
        checks++;
        assert ((got & mask) === (exp & mask)) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got & mask, exp & mask);
        end
    endtask

    // Expected output sequence of one division: per digit, LINES sweep cycles
    // writing consecutive addresses, then LINES fix cycles re-reading those
    // addresses if the digit is flagged; finally one DONE cycle.
    function automatic void build(input int which, input logic [7:0] err);
        int    lines = 4;
        int    nd    = (which == 0) ? 2 : 3;
        int    m     = (which == 0) ? 128 : 8;
        int    ptr   = 0;
        step_t s;
        plan.delete();
        for (int d = 0; d < nd; d++) begin
            for (int l = 0; l < lines; l++) begin
                s.exp = '0; s.mask = '1; s.dig = d;
                s.exp.busy       = 1'b1;
                s.exp.enable_all = 1'b1;
                s.exp.en_q       = (l == 0) ? 2'd1 : 2'd0;
                s.exp.en_cout    = (l < lines - 1);
                s.exp.en_shift   = (l == lines - 1) ? 2'd2 : 2'd1;
                s.exp.en_v_upper = (l == lines - 1);
                s.exp.wr         = 7'(ptr % m);
                s.exp.digit      = 4'(d);
                s.err_pt         = (l == lines - 1);
                plan.push_back(s);
                ptr++;
            end
            if (err[d]) begin
                for (int l = 0; l < lines; l++) begin
                    s.exp = '0; s.mask = '1; s.dig = d;
                    s.mask.wr        = '0;   // no write happens during a fix pass
                    s.exp.busy       = 1'b1;
                    s.exp.enable_all = 1'b1;
                    s.exp.fixing     = 1'b1;
                    s.exp.en_borrow  = (l == lines - 1) ? 2'd2 : 2'd1;
                    s.exp.rd         = 7'((ptr - lines + l) % m);
                    s.exp.digit      = 4'(d);
                    s.err_pt         = 1'b0;
                    plan.push_back(s);
                end
            end
        end
        s.exp = '0; s.mask = '1; s.dig = nd; s.err_pt = 1'b0;
        s.exp.busy  = 1'b1;
        s.exp.done  = 1'b1;
        s.exp.wr    = 7'(ptr % m);
        s.exp.digit = 4'(nd);
        plan.push_back(s);
    endfunction

    // Runs one division on instance `which`. hold keeps start high all the way
    // through; pre_started means start was already sampled in IDLE by the
    // caller. abort_at >= 0 pulses the clear during that step and ends the run.
    task automatic run_div(input int which, input logic [7:0] err, input bit hold,
                           input bit pre_started, input int abort_at, input string name);
        logic ef;
        logic sf;
        build(which, err);
        if (!pre_started) begin
            @(negedge clk);
            drive(which, 1'b1, 1'($urandom));
        end
        foreach (plan[i]) begin
            @(negedge clk);
            check($sformatf("%s step%0d", name, i), sample(which), plan[i].exp, plan[i].mask);
            if (i == abort_at) begin
                async_clear = 1'b1;
                drive(which, 1'b1, 1'b1);
                @(negedge clk);
                async_clear = 1'b0;
                drive(which, 1'b0, 1'b0);
                check($sformatf("%s cleared", name), sample(which), '0, '1);
                return;
            end
            ef = plan[i].err_pt ? err[plan[i].dig] : 1'($urandom);
            sf = hold ? 1'b1 : ((i == plan.size() - 1) ? 1'b0 : 1'($urandom));
            drive(which, sf, ef);
        end
        @(negedge clk);
        check($sformatf("%s idle", name), sample(which), '0, '1);
    endtask

    initial begin
        async_clear = 1'b1;
        drive(0, 1'b0, 1'b0);
        drive(1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("reset a", sample(0), '0, '1);
        check("reset b", sample(1), '0, '1);
        async_clear = 1'b0;

        // Plain two-digit division, no fix: DONE on the ninth cycle.
        run_div(0, 8'h00, 1'b0, 1'b0, -1, "plain");
        // Fix after digit 0: reads 0..3, digit 1 writes 4..7.
        run_div(0, 8'h01, 1'b0, 1'b0, -1, "fix_d0");
        // Wrap on the 3-bit RAM, fix on digit 2 reads 0..3.
        run_div(1, 8'h04, 1'b0, 1'b0, -1, "wrap_fix_d2");
        // Clear during the second fix cycle, then a fresh division from 0.
        run_div(0, 8'h01, 1'b0, 1'b0, 5, "clear_fix");
        run_div(0, 8'h00, 1'b0, 1'b0, -1, "after_clear");

        // Clear and start together in IDLE: clear wins.
        @(negedge clk);
        async_clear = 1'b1;
        drive(0, 1'b1, 1'b0);
        @(negedge clk);
        check("clear_vs_start", sample(0), '0, '1);
        async_clear = 1'b0;
        drive(0, 1'b0, 1'b0);
        @(negedge clk);
        check("clear_vs_start held", sample(0), '0, '1);

        // start held high: one IDLE cycle, then the next division.
        run_div(0, 8'h02, 1'b1, 1'b0, -1, "hold_first");
        run_div(0, 8'h03, 1'b0, 1'b1, -1, "hold_second");

        for (int k = 0; k < 24; k++) begin
            int which;
            int ab;
            which = int'($urandom_range(0, 1));
            ab    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 16)) : -1;
            run_div(which, 8'($urandom), 1'b0, 1'b0, ab, $sformatf("rnd%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_iter_ctrl.md
DIV_ITER_CTRL -- requirements
Module: div_iter_ctrl

Interface
REQ-001 Parameter UNROLLING, default 4: digits per residue line; must match the v-value datapath.
REQ-002 Parameter LINES, default 4: residue lines per iteration, LSD line first; LINES >= 2.
REQ-003 Parameter NUM_DIGITS, default 16: quotient digits per division.
REQ-004 Parameter RAM_width, default 7: V RAM address width.
REQ-005 Port clk, input, 1: the only clock; all state updates on its rising edge.
REQ-006 Port async_clear, input, 1: reset; synchronous and active-high (sampled only at the clk rising edge).
REQ-007 Port start, input, 1: begin a division; sampled in IDLE only.
REQ-008 Port error_flag, input, 1: datapath request to fix the current digit; sampled in the last SWEEP cycle.
REQ-009 Port enable_all, output, 1: datapath carry-register enable.
REQ-010 Port en_cout, output, 1: carry line-to-line propagate.
REQ-011 Port en_q, output, 2: 1 = load the quotient vector into the adder.
REQ-012 Port en_shift, output, 2: 1 = mid line written, 2 = last line written, 0 = no write.
REQ-013 Port en_borrow, output, 2: 1 = mid-line borrow, 2 = MSD borrow, 0 = off.
REQ-014 Port en_v_upper, output, 1: MSD (upper-bits) update cycle.
REQ-015 Port fixing, output, 1: fix pass active.
REQ-016 Port wr_V_ram, output, RAM_width: V RAM write address.
REQ-017 Port rd_V_ram, output, RAM_width: V RAM read address.
REQ-018 Port busy, output, 1: high outside IDLE.
REQ-019 Port done, output, 1: one-cycle completion pulse.
REQ-020 Port digit_cnt, output, clog2(NUM_DIGITS+1): index of the current digit.

Function
REQ-021 The FSM SHALL have the states IDLE, SWEEP, FIX and DONE, with internal line_cnt 0..LINES-1.
REQ-022 IDLE SHALL drive all outputs to 0 and ignore error_flag; start=1 moves to SWEEP next cycle with line_cnt=0, digit_cnt=0 and wr pointer=0.
REQ-023 SWEEP SHALL last LINES cycles, with enable_all=1 and fixing=0.
REQ-024 In SWEEP, en_q SHALL be 1 on line 0 only and 0 otherwise.
REQ-025 In SWEEP, en_cout SHALL be 1 on lines 0..LINES-2 and 0 on the last line.
REQ-026 In SWEEP, en_shift SHALL be 1 on lines 0..LINES-2 and 2 on the last line.
REQ-027 In SWEEP, en_v_upper SHALL be 1 on the last line only, and en_borrow SHALL be 0.
REQ-028 In SWEEP, wr_V_ram SHALL equal the wr pointer, which increments each cycle and wraps from 2^RAM_width-1 to 0.
REQ-029 At the end of the last SWEEP cycle, error_flag=1 SHALL go to FIX; otherwise digit_cnt SHALL increment and the FSM SHALL go to SWEEP, or to DONE if digit_cnt was NUM_DIGITS-1.
REQ-030 FIX SHALL last LINES cycles with fixing=1, enable_all=1, en_shift=0 and en_q=0.
REQ-031 In FIX, en_borrow SHALL be 1 on lines 0..LINES-2 and 2 on the last line.
REQ-032 In FIX, rd_V_ram SHALL equal (wr pointer - LINES + line_cnt) mod 2^RAM_width, i.e. the lines of this digit.
REQ-033 At the end of FIX, digit_cnt SHALL increment and the FSM SHALL leave as in REQ-029; error_flag SHALL be ignored during FIX.
REQ-034 DONE SHALL last one cycle with done=1 and busy=1, then return to IDLE.
REQ-035 start asserted while busy SHALL be ignored.
REQ-036 All outputs SHALL be registered, or decoded from registered state only, with no combinational path from the inputs.
REQ-037 Outside SWEEP and FIX, rd_V_ram SHALL be 0 and wr_V_ram SHALL hold the pointer value.

Reset
REQ-038 async_clear=1 at a clock edge SHALL force IDLE and clear line_cnt, digit_cnt, the pointers and all outputs, in any state including mid-SWEEP or mid-FIX.
REQ-039 async_clear SHALL take priority over start in the same cycle.

Structure
REQ-040 Package div_ctrl_pkg SHALL hold the state enum and the 2-bit encodings EN_OFF=0, EN_MID=1, EN_LAST=2.
REQ-041 Sub-module div_addr_gen SHALL hold the wrapping wr pointer and the rd address computation.

Verification
REQ-042 Reset, then start=1 for 1 cycle with LINES=4, NUM_DIGITS=2 and error_flag=0 -> en_shift per digit is 1,1,1,2; wr_V_ram is 0..7; done pulses at cycle 9 after start.
REQ-043 error_flag=1 during the last SWEEP line of digit 0 -> 4 FIX cycles follow with rd_V_ram 0,1,2,3 and en_borrow 1,1,1,2, then digit 1 SWEEP with wr_V_ram 4..7.
REQ-044 Wrap with RAM_width=3, LINES=4, NUM_DIGITS=3 -> wr_V_ram runs 0..7 then 0..3; a FIX on digit 2 reads addresses 0..3.
REQ-045 async_clear pulsed at the second FIX cycle -> the next cycle shows IDLE with all outputs 0; a fresh start restarts from wr_V_ram=0.
REQ-046 start held high throughout a division -> no restart until IDLE; a new division begins the cycle after IDLE is re-entered.
